// File: rtl/bram_capture_ctrl_pkg.sv
// bram_capture_ctrl_pkg: shared state encoding and default BRAM geometry for the capture controller and the bram instance
package bram_capture_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;
    localparam int NB_ADDR_DEF = 11;
    localparam int NB_DATA_DEF = 14;
    localparam int DEPTH_DEF   = 2048;
endpackage

// File: rtl/bram_capture_ctrl_if.sv
// bram_capture_ctrl_if: capture-controller bus; inputs i_start/i_clear/i_valid/i_data/i_read_step, outputs o_write_enable/o_write_addr/o_write_data/o_read_addr/o_full/o_busy/o_fill_count
interface bram_capture_ctrl_if #(
    parameter int NB_ADDR = bram_capture_ctrl_pkg::NB_ADDR_DEF,
    parameter int NB_DATA = bram_capture_ctrl_pkg::NB_DATA_DEF
);
    logic               i_start;
    logic               i_clear;
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
    logic               i_read_step;
    logic               o_write_enable;
    logic [NB_ADDR-1:0] o_write_addr;
    logic [NB_DATA-1:0] o_write_data;
    logic [NB_ADDR-1:0] o_read_addr;
    logic               o_full;
    logic               o_busy;
    logic [NB_ADDR:0]   o_fill_count;
    modport master (
        output i_start, i_clear, i_valid, i_data, i_read_step,
        input  o_write_enable, o_write_addr, o_write_data, o_read_addr, o_full, o_busy, o_fill_count
    );
    modport slave (
        input  i_start, i_clear, i_valid, i_data, i_read_step,
        output o_write_enable, o_write_addr, o_write_data, o_read_addr, o_full, o_busy, o_fill_count
    );
endinterface

// File: rtl/bram_capture_ctrl_rising_edge_detect.sv
// rising_edge_detect: one-cycle pulse on a 0->1 transition; ports clock, i_reset, i_signal in, o_pulse out
module rising_edge_detect (
    input  logic clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_pulse
);
    logic prev;
    always_ff @(posedge clock)
        prev <= i_reset ? 1'b0 : i_signal;
    assign o_pulse = i_signal & ~prev;
endmodule

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: one-shot BRAM capture sequencer (fill on start edge, then playback addressing); ports clock, i_reset, bus (slave)
module bram_capture_ctrl
    import bram_capture_ctrl_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input logic                 clock,
    input logic                 i_reset,
    bram_capture_ctrl_if.slave  bus
);
    localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(DEPTH - 1);
    state_t             state, state_n;
    logic [NB_ADDR-1:0] wr_ptr, wr_ptr_n;
    logic [NB_ADDR-1:0] read_addr, read_addr_n;
    logic [NB_ADDR-1:0] write_addr, write_addr_n;
    logic [NB_DATA-1:0] write_data, write_data_n;
    logic               write_enable, write_enable_n;
    logic [NB_ADDR:0]   fill_count, fill_count_n;
    logic               start_pulse;
    rising_edge_detect u_start_edge (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_signal (bus.i_start),
        .o_pulse  (start_pulse)
    );
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            read_addr    <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            fill_count   <= '0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            read_addr    <= read_addr_n;
            write_addr   <= write_addr_n;
            write_data   <= write_data_n;
            write_enable <= write_enable_n;
            fill_count   <= fill_count_n;
        end
    end
    // Samples only count while the switch is held high; dropping it pauses the fill.
    always_comb begin
        state_n        = state;
        wr_ptr_n       = wr_ptr;
        read_addr_n    = read_addr;
        write_addr_n   = write_addr;
        write_data_n   = write_data;
        write_enable_n = 1'b0;
        fill_count_n   = fill_count;
        if (bus.i_clear) begin
            state_n      = IDLE;
            wr_ptr_n     = '0;
            read_addr_n  = '0;
            fill_count_n = '0;
        end else begin
            case (state)
                IDLE: state_n = start_pulse ? CAPTURE : IDLE;
                CAPTURE: begin
                    if (bus.i_valid && bus.i_start) begin
                        write_enable_n = 1'b1;
                        write_addr_n   = wr_ptr;
                        write_data_n   = bus.i_data;
                        wr_ptr_n       = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                        fill_count_n   = fill_count + 1'b1;
                        state_n        = (wr_ptr == LAST) ? FULL : CAPTURE;
                    end
                end
                FULL: begin
                    if (start_pulse) begin
                        state_n      = CAPTURE;
                        wr_ptr_n     = '0;
                        read_addr_n  = '0;
                        fill_count_n = '0;
                    end else if (bus.i_read_step) begin
                        read_addr_n = (read_addr == LAST) ? '0 : read_addr + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign bus.o_write_enable = write_enable;
    assign bus.o_write_addr   = write_addr;
    assign bus.o_write_data   = write_data;
    assign bus.o_read_addr    = read_addr;
    assign bus.o_fill_count   = fill_count;
    assign bus.o_full         = (state == FULL);
    assign bus.o_busy         = (state == CAPTURE);
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl: directed plus random stimulus checked each cycle against a behavioural capture model
module tb_bram_capture_ctrl;
    localparam int NB_ADDR = 3;
    localparam int NB_DATA = 14;
    localparam int DEPTH   = 8;
    logic clock = 1'b0;
    logic i_reset;
    int n_checks = 0;
    int n_fails  = 0;
    int m_mode, m_prev, m_wp, m_cnt, m_ra, m_we, m_wa, m_wd;
    int mem [DEPTH];
    always #5 clock = ~clock;
    bram_capture_ctrl_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus ();
    bram_capture_ctrl #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // mode: 0 idle, 1 filling, 2 holding a complete capture
    task automatic model(input bit rst, clr, st, v, input int d, input bit rs);
        bit pulse;
        pulse = st && !m_prev;
        if (rst) begin
            {m_mode, m_prev, m_wp, m_cnt, m_ra, m_we, m_wa, m_wd} = '0;
            return;
        end
        m_prev = st;
        m_we   = 0;
        if (clr) begin
            m_mode = 0; m_wp = 0; m_cnt = 0; m_ra = 0;
        end else if (m_mode == 0) begin
            if (pulse) m_mode = 1;
        end else if (m_mode == 1) begin
            if (v && st) begin
                m_we = 1; m_wa = m_wp; m_wd = d;
                mem[m_wp] = d;
                m_cnt++;
                m_wp = (m_wp + 1) % DEPTH;
                if (m_cnt == DEPTH) m_mode = 2;
            end
        end else if (pulse) begin
            m_mode = 1; m_wp = 0; m_cnt = 0; m_ra = 0;
        end else if (rs) begin
            m_ra = (m_ra + 1) % DEPTH;
        end
    endtask
    task automatic cyc(input bit rst, clr, st, v, input int d, input bit rs);
        i_reset         = rst;
        bus.i_clear     = clr;
        bus.i_start     = st;
        bus.i_valid     = v;
        bus.i_data      = NB_DATA'(d);
        bus.i_read_step = rs;
        @(posedge clock);
        model(rst, clr, st, v, d, rs);
        #1;
        chk("write_enable", 32'(bus.o_write_enable), 32'(m_we));
        chk("read_addr", 32'(bus.o_read_addr), 32'(m_ra));
        chk("full", 32'(bus.o_full), 32'(m_mode == 2));
        chk("busy", 32'(bus.o_busy), 32'(m_mode == 1));
        chk("fill_count", 32'(bus.o_fill_count), 32'(m_cnt));
        if (m_we == 1) begin
            chk("write_addr", 32'(bus.o_write_addr), 32'(m_wa));
            chk("write_data", 32'(bus.o_write_data), 32'(m_wd));
        end
        if (rst) begin
            chk("reset_write_addr", 32'(bus.o_write_addr), 32'd0);
            chk("reset_write_data", 32'(bus.o_write_data), 32'd0);
        end
    endtask
    initial begin
        bit st;
        // reset held with valid pulses, then idle valid without a start edge
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, i % 2, 100 + i, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 200 + i, 0);
        // first fill: data 1..8 to addr 0..7
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) cyc(0, 0, 1, 1, i, 0);
        chk("first_fill_full", 32'(bus.o_full), 32'd1);
        chk("first_fill_last_addr", 32'(bus.o_write_addr), 32'd7);
        chk("first_fill_count", 32'(bus.o_fill_count), 32'd8);
        cyc(0, 0, 1, 1, 99, 0);
        chk("no_write_in_full", 32'(bus.o_write_enable), 32'd0);
        // restart, pause 3 cycles mid-fill, resume at held address
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 11, 0);
        cyc(0, 0, 1, 1, 12, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 50 + i, 0);
        chk("pause_count_held", 32'(bus.o_fill_count), 32'd2);
        cyc(0, 0, 1, 1, 13, 0);
        chk("resume_addr", 32'(bus.o_write_addr), 32'd2);
        for (int i = 14; i <= 18; i++) cyc(0, 0, 1, 1, i, 0);
        // playback: 10 steps wrap at DEPTH
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 1);
        chk("playback_wrap_addr", 32'(bus.o_read_addr), 32'd2);
        // clear at count 4 coincident with a start rise
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 30 + i, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 1, 77, 0);
        chk("clear_idle_count", 32'(bus.o_fill_count), 32'd0);
        cyc(0, 0, 1, 1, 78, 0);
        cyc(0, 0, 0, 1, 79, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 1, 40 + i, 0);
        for (int i = 0; i < DEPTH; i++) chk("mem_contents", 32'(mem[i]), 32'(40 + i));
        // toggle start in FULL, fresh capture, then reset mid-fill
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 60, 1);
        chk("restart_read_addr", 32'(bus.o_read_addr), 32'd0);
        cyc(0, 0, 1, 1, 61, 0);
        chk("restart_addr0", 32'(bus.o_write_addr), 32'd0);
        cyc(0, 0, 1, 1, 62, 0);
        cyc(1, 0, 1, 1, 63, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // random traffic
        st = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) st = ~st;
            cyc($urandom_range(99) == 0, $urandom_range(49) == 0, st,
                $urandom_range(9) < 7, int'($urandom_range(16383)), $urandom_range(1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
